seq_shift_right: RTL

//  Multi-cycle right shifter for the datapath's 16-bit words; the inverse

---
 rtl/seq_shift_right.sv | 107 ++++++++++
 1 files changed

// File: rtl/seq_shift_right.sv
// Multi-cycle right shifter. It moves the word one bit per clock and fills
// with zero (logical) or with the sign bit latched at accept (arithmetic).
// The control unit talks to it through start/busy/done. A shift amount of
// zero skips SHIFT and goes straight to DONE.
module seq_shift_right #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   cnt_q;
    logic             fill_q;
    logic [WIDTH-1:0] out_q;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] shifted;

    // A new request is taken only when no operation is in flight.
    assign accept    = start && (state_q == IDLE || state_q == DONE);
    assign last_step = (state_q == SHIFT) && (cnt_q == SHW'(1));
    assign shifted   = {fill_q, data_q[WIDTH-1:1]};

    // State register; reset abandons any operation in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: every register in an always_ff takes <= so that all flops
        // sample the values from before the edge, whatever order the
        // statements are written in.
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept from IDLE/DONE, count down in SHIFT.
    always_comb begin
        // NOTE: the default assigned first keeps every path driven, so
        // no latch can be inferred when a branch says nothing about state_d.
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture the operand at accept, shift one bit per SHIFT
    // cycle, and write the result register only on the edge into DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: the datapath is only a handful of flops, so all of it is
        // reset. After an abandoned operation no stale data or count
        // survives.
        if (!RST_N) begin
            data_q <= '0;
            cnt_q  <= '0;
            fill_q <= 1'b0;
            out_q  <= '0;
        end else if (accept) begin
            data_q <= in;
            cnt_q  <= shamt;
            fill_q <= arith & in[WIDTH-1];
            if (shamt == '0) begin
                out_q <= in;
            end
        end else if (state_q == SHIFT) begin
            data_q <= shifted;
            cnt_q  <= cnt_q - SHW'(1);
            if (last_step) begin
                out_q <= shifted;
            end
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign out  = out_q;

endmodule
